// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_align.sv
// Width decode for RV32I accesses: store lane steering, load
// extraction/extension, alignment and illegal-code checks.
module load_store_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] wr_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] rd_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wdata      = '0;
    be         = '0;
    rd_ext     = '0;
    misaligned = 1'b0;
    illegal    = is_load && is_store;
    if (is_load) begin
      unique case (funct3)
        F3_B:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
        F3_BU: rd_ext = {24'd0, rd_byte};
        F3_H: begin
          misaligned = addr_lo[0];
          rd_ext     = {{16{rd_half[15]}}, rd_half};
        end
        F3_HU: begin
          misaligned = addr_lo[0];
          rd_ext     = {16'd0, rd_half};
        end
        F3_W: begin
          misaligned = |addr_lo;
          rd_ext     = rdata;
        end
        default: illegal = 1'b1;
      endcase
    end else if (is_store) begin
      unique case (funct3)
        F3_B: begin
          wdata = {4{wr_data[7:0]}};
          be    = 4'b0001 << addr_lo;
        end
        F3_H: begin
          misaligned = addr_lo[0];
          wdata      = {2{wr_data[15:0]}};
          be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
        F3_W: begin
          misaligned = |addr_lo;
          wdata      = wr_data;
          be         = 4'b1111;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: valid/ready data bus master with
// width steering, load extension, stall and fault reporting.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rd_data_o,
  output logic [1:0]  fault_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ready_i,
  input  logic [31:0] bus_rdata_i
);

  localparam bit TO_EN = TIMEOUT_CYCLES != 0;
  localparam int CW =
    TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_I =
    TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];

  state_t          state, state_n;
  logic            start;
  logic            to_hit;
  logic [CW-1:0]   cnt;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_lo;

  logic [31:0]     st_wdata;
  logic [3:0]      st_be;
  logic            st_mis;
  logic            st_ill;
  logic [31:0]     st_unused_rd;

  logic [31:0]     ld_ext;
  logic [31:0]     ld_unused_wdata;
  logic [3:0]      ld_unused_be;
  logic            ld_unused_mis;
  logic            ld_unused_ill;

  assign start  = req_valid_i && (mem_rd_i || mem_wr_i);
  assign to_hit = TO_EN && (cnt == TO_LAST);

  load_store_align u_req_align (
    .funct3     (funct3_i),
    .addr_lo    (addr_i[1:0]),
    .is_load    (mem_rd_i),
    .is_store   (mem_wr_i),
    .wr_data    (wr_data_i),
    .rdata      (32'd0),
    .wdata      (st_wdata),
    .be         (st_be),
    .rd_ext     (st_unused_rd),
    .misaligned (st_mis),
    .illegal    (st_ill)
  );

  load_store_align u_rd_align (
    .funct3     (ld_f3),
    .addr_lo    (ld_lo),
    .is_load    (1'b1),
    .is_store   (1'b0),
    .wr_data    (32'd0),
    .rdata      (bus_rdata_i),
    .wdata      (ld_unused_wdata),
    .be         (ld_unused_be),
    .rd_ext     (ld_ext),
    .misaligned (ld_unused_mis),
    .illegal    (ld_unused_ill)
  );

  always_comb begin
    state_n   = state;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    bus_req_o = 1'b0;
    unique case (state)
      S_IDLE: begin
        stall_o = start;
        if (start)
          state_n = (st_ill || st_mis) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        stall_o   = 1'b1;
        bus_req_o = 1'b1;
        if (bus_ready_i || to_hit)
          state_n = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_be_o    <= '0;
      rd_data_o   <= '0;
      fault_o     <= FAULT_NONE;
      cnt         <= '0;
      ld_f3       <= '0;
      ld_lo       <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (st_ill) begin
              fault_o   <= FAULT_ILLEGAL;
              rd_data_o <= '0;
            end else if (st_mis) begin
              fault_o   <= FAULT_MISALIGN;
              rd_data_o <= '0;
            end else begin
              bus_we_o    <= mem_wr_i;
              bus_addr_o  <= {addr_i[31:2], 2'b00};
              bus_wdata_o <= st_wdata;
              bus_be_o    <= st_be;
              ld_f3       <= funct3_i;
              ld_lo       <= addr_i[1:0];
              cnt         <= '0;
            end
          end
        end
        S_REQ: begin
          // ready in the final timeout cycle still completes cleanly
          if (bus_ready_i) begin
            fault_o   <= FAULT_NONE;
            rd_data_o <= bus_we_o ? '0 : ld_ext;
          end else if (to_hit) begin
            fault_o   <= FAULT_TIMEOUT;
            rd_data_o <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rd_data_o;
  logic [1:0]  fault_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ready_i;
  logic [31:0] bus_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .mem_rd_i    (mem_rd_i),
    .mem_wr_i    (mem_wr_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wr_data_i   (wr_data_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .rd_data_o   (rd_data_o),
    .fault_o     (fault_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_be_o    (bus_be_o),
    .bus_ready_i (bus_ready_i),
    .bus_rdata_i (bus_rdata_i)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        bus;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  be;
    logic        we;
    logic [1:0]  fault;
    logic [31:0] rdx;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int i);
    @(negedge clk);
    req_valid_i = 1'b1;
    mem_rd_i    = v.rd;
    mem_wr_i    = v.wr;
    funct3_i    = v.f3;
    addr_i      = v.addr;
    wr_data_i   = v.wdat;
    bus_rdata_i = v.rdat;
    bus_ready_i = 1'b0;
    #1;
    check($sformatf("v%0d_stall_c0", i), 32'(stall_o), 32'd1);
    check($sformatf("v%0d_req_c0", i), 32'(bus_req_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (v.bus) begin
      check($sformatf("v%0d_req_c1", i), 32'(bus_req_o), 32'd1);
      check($sformatf("v%0d_stall_c1", i), 32'(stall_o), 32'd1);
      check($sformatf("v%0d_addr", i), bus_addr_o, v.baddr);
      check($sformatf("v%0d_wdata", i), bus_wdata_o, v.bwdata);
      check($sformatf("v%0d_be", i), 32'(bus_be_o), 32'(v.be));
      check($sformatf("v%0d_we", i), 32'(bus_we_o), 32'(v.we));
      check($sformatf("v%0d_done_c1", i), 32'(done_o), 32'd0);
      bus_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_ready_i = 1'b0;
    end else begin
      check($sformatf("v%0d_noreq", i), 32'(bus_req_o), 32'd0);
    end
    check($sformatf("v%0d_done", i), 32'(done_o), 32'd1);
    check($sformatf("v%0d_stall_done", i), 32'(stall_o), 32'd0);
    check($sformatf("v%0d_fault", i), 32'(fault_o), 32'(v.fault));
    check($sformatf("v%0d_rdata", i), rd_data_o, v.rdx);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    check($sformatf("v%0d_done_off", i), 32'(done_o), 32'd0);
    check($sformatf("v%0d_hold", i), rd_data_o, v.rdx);
  endtask

  task automatic timeout_seq(input logic late, input string nm);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1;
    mem_rd_i    = 1'b1;
    mem_wr_i    = 1'b0;
    funct3_i    = 3'b010;
    addr_i      = 32'h0000_0300;
    bus_rdata_i = 32'h1122_3344;
    bus_ready_i = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (bus_req_o) n++;
        bus_ready_i = late && (n == 4);
        @(posedge clk);
      end
    end
    bus_ready_i = 1'b0;
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
    check({nm, "_req_cycles"}, n, 4);
    check({nm, "_fault"}, 32'(fault_o), late ? 32'd0 : 32'd2);
    check({nm, "_rdata"}, rd_data_o,
          late ? 32'h1122_3344 : 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF,
                 1, 32'h100, 0, 4'b0000, 0, 2'b00, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 0, 32'h80FF0000,
                 1, 32'h100, 0, 4'b0000, 0, 2'b00, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 3'b100, 32'h103, 0, 32'h80FF0000,
                 1, 32'h100, 0, 4'b0000, 0, 2'b00, 32'h00000080};
    vecs[3]  = '{1, 0, 3'b001, 32'h102, 0, 32'h80FF0000,
                 1, 32'h100, 0, 4'b0000, 0, 2'b00, 32'hFFFF80FF};
    vecs[4]  = '{1, 0, 3'b101, 32'h102, 0, 32'h80FF0000,
                 1, 32'h100, 0, 4'b0000, 0, 2'b00, 32'h000080FF};
    vecs[5]  = '{0, 1, 3'b000, 32'h201, 32'h12345678, 32'hFFFFFFFF,
                 1, 32'h200, 32'h78787878, 4'b0010, 1, 2'b00, 0};
    vecs[6]  = '{0, 1, 3'b001, 32'h202, 32'h12345678, 32'hFFFFFFFF,
                 1, 32'h200, 32'h56785678, 4'b1100, 1, 2'b00, 0};
    vecs[7]  = '{0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0,
                 1, 32'h204, 32'hCAFEF00D, 4'b1111, 1, 2'b00, 0};
    vecs[8]  = '{1, 0, 3'b010, 32'h102, 0, 32'h12345678,
                 0, 0, 0, 0, 0, 2'b01, 0};
    vecs[9]  = '{1, 1, 3'b010, 32'h100, 0, 32'h12345678,
                 0, 0, 0, 0, 0, 2'b11, 0};
    vecs[10] = '{1, 0, 3'b011, 32'h100, 0, 32'h12345678,
                 0, 0, 0, 0, 0, 2'b11, 0};
    vecs[11] = '{0, 1, 3'b100, 32'h100, 32'h55, 0,
                 0, 0, 0, 0, 0, 2'b11, 0};
    vecs[12] = '{0, 1, 3'b001, 32'h203, 32'h1234, 0,
                 0, 0, 0, 0, 0, 2'b01, 0};
    vecs[13] = '{1, 0, 3'b000, 32'h101, 0, 32'h00007F00,
                 1, 32'h100, 0, 4'b0000, 0, 2'b00, 32'h0000007F};
    vecs[14] = '{1, 0, 3'b001, 32'h100, 0, 32'h1234FFFE,
                 1, 32'h100, 0, 4'b0000, 0, 2'b00, 32'hFFFFFFFE};

    reset       = 1'b1;
    req_valid_i = 1'b0;
    mem_rd_i    = 1'b0;
    mem_wr_i    = 1'b0;
    funct3_i    = '0;
    addr_i      = '0;
    wr_data_i   = '0;
    bus_ready_i = 1'b0;
    bus_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_req", 32'(bus_req_o), 32'd0);
    check("rst_we", 32'(bus_we_o), 32'd0);
    check("rst_addr", bus_addr_o, 32'd0);
    check("rst_wdata", bus_wdata_o, 32'd0);
    check("rst_be", 32'(bus_be_o), 32'd0);
    check("rst_rdata", rd_data_o, 32'd0);
    check("rst_fault", 32'(fault_o), 32'd0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    timeout_seq(1'b0, "tmo");
    timeout_seq(1'b1, "late_ready");

    @(negedge clk);
    req_valid_i = 1'b1;
    mem_rd_i    = 1'b1;
    mem_wr_i    = 1'b0;
    funct3_i    = 3'b010;
    addr_i      = 32'h400;
    bus_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_req1", 32'(bus_req_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("mid_req2", 32'(bus_req_o), 32'd1);
    reset       = 1'b1;
    req_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_req", 32'(bus_req_o), 32'd0);
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid_rst_nodone%0d", k), 32'(done_o), 32'd0);
      @(negedge clk);
    end
    run_vec(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
